// File: rtl/lane_descrambler_nsym.sv
// Per-lane Rx descrambler: NSYM symbols per clock, LFSR chained across slots, COM-based lock.
// Optional COM/SKP statistics counters are built when DESCRAM_STATS_EN is defined.
module lane_descrambler_nsym #(
    parameter int          NSYM      = 1,
    parameter logic [15:0] LFSR_SEED = 16'hFFFF,
    parameter int          CNT_W     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [8*NSYM-1:0]   in_data,
    input  logic [NSYM-1:0]     in_k,
    input  logic [NSYM-1:0]     in_ts,
    input  logic                scram_en,
    output logic                out_valid,
    output logic [8*NSYM-1:0]   out_data,
    output logic [NSYM-1:0]     out_k,
    output logic                out_locked,
    output logic [CNT_W-1:0]    com_cnt,
    output logic [CNT_W-1:0]    skp_cnt
);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

    // Eight serial Galois shifts of x^16+x^5+x^4+x^3+1.
    function automatic logic [15:0] lfsr_adv8(input logic [15:0] l);
        logic [15:0] s;
        logic        fb;
        s = l;
        for (int b = 0; b < 8; b++) begin
            fb   = s[15];
            s    = {s[14:0], 1'b0};
            s[0] = fb;
            s[3] = s[3] ^ fb;
            s[4] = s[4] ^ fb;
            s[5] = s[5] ^ fb;
        end
        return s;
    endfunction

    function automatic logic [7:0] lfsr_mask(input logic [15:0] l);
        logic [7:0] m;
        for (int i = 0; i < 8; i++) begin
            m[i] = l[15-i];
        end
        return m;
    endfunction

    logic [15:0]         lfsr_reg;
    logic [15:0]         lfsr_next;
    logic [8*NSYM-1:0]   data_next;
    logic [NSYM-1:0]     com_vec;
    logic [NSYM-1:0]     skp_vec;
    logic                out_valid_reg;
    logic [8*NSYM-1:0]   out_data_reg;
    logic [NSYM-1:0]     out_k_reg;
    lock_state_t         state_reg;
    lock_state_t         state_next;

    generate
        for (genvar gi = 0; gi < NSYM; gi++) begin : g_slot
            assign com_vec[gi] = in_k[gi] && (in_data[8*gi +: 8] == 8'hBC);
            assign skp_vec[gi] = in_k[gi] && (in_data[8*gi +: 8] == 8'h1C);
        end
    endgenerate

    // Walk the slots in wire order; each slot sees the LFSR left by the previous one.
    always_comb begin : slot_chain
        logic [15:0] l;
        l         = lfsr_reg;
        data_next = in_data;
        for (int j = 0; j < NSYM; j++) begin
            if (com_vec[j]) begin
                l = LFSR_SEED;
            end else if (!skp_vec[j] && scram_en) begin
                if (!in_k[j] && !in_ts[j]) begin
                    data_next[8*j +: 8] = in_data[8*j +: 8] ^ lfsr_mask(l);
                end
                l = lfsr_adv8(l);
            end
        end
        lfsr_next = l;
    end

    always_comb begin
        state_next = state_reg;
        if (state_reg == UNLOCKED && in_valid && (|com_vec)) begin
            state_next = LOCKED;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr_reg      <= LFSR_SEED;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_k_reg     <= '0;
            state_reg     <= UNLOCKED;
        end else begin
            state_reg     <= state_next;
            out_valid_reg <= in_valid;
            if (in_valid) begin
                lfsr_reg     <= lfsr_next;
                out_data_reg <= data_next;
                out_k_reg    <= in_k;
            end
        end
    end

    assign out_valid  = out_valid_reg;
    assign out_data   = out_data_reg;
    assign out_k      = out_k_reg;
    assign out_locked = (state_reg == LOCKED);

`ifdef DESCRAM_STATS_EN
    function automatic logic [CNT_W:0] count_ones(input logic [NSYM-1:0] v);
        logic [CNT_W:0] c;
        c = '0;
        for (int i = 0; i < NSYM; i++) begin
            c = c + {{CNT_W{1'b0}}, v[i]};
        end
        return c;
    endfunction

    // Carry out of the widened sum means the counter would pass all-ones.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [CNT_W:0] n);
        logic [CNT_W:0] s;
        s = {1'b0, c} + n;
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    logic [CNT_W-1:0] com_cnt_reg;
    logic [CNT_W-1:0] skp_cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            com_cnt_reg <= '0;
            skp_cnt_reg <= '0;
        end else if (in_valid) begin
            com_cnt_reg <= sat_add(com_cnt_reg, count_ones(com_vec));
            skp_cnt_reg <= sat_add(skp_cnt_reg, count_ones(skp_vec));
        end
    end

    assign com_cnt = com_cnt_reg;
    assign skp_cnt = skp_cnt_reg;
`else
    assign com_cnt = '0;
    assign skp_cnt = '0;
`endif

endmodule

// File: tb/tb_lane_descrambler_nsym.sv
// Bench for lane_descrambler_nsym: an NSYM=1 (CNT_W=4) and an NSYM=4 instance checked against a symbol-level model.
module tb_lane_descrambler_nsym;

    localparam logic [15:0] SEED = 16'hFFFF;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        v1, k1, ts1, se1;
    logic [7:0]  d1;
    logic        ov1, ok1, olk1;
    logic [7:0]  od1;
    logic [3:0]  cc1, sc1;

    logic        v4, se4;
    logic [31:0] d4;
    logic [3:0]  k4, ts4;
    logic        ov4, olk4;
    logic [31:0] od4;
    logic [3:0]  ok4;
    logic [15:0] cc4, sc4;

    lane_descrambler_nsym #(.NSYM(1), .LFSR_SEED(SEED), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_data(d1), .in_k(k1), .in_ts(ts1),
        .scram_en(se1), .out_valid(ov1), .out_data(od1), .out_k(ok1),
        .out_locked(olk1), .com_cnt(cc1), .skp_cnt(sc1));

    lane_descrambler_nsym #(.NSYM(4), .LFSR_SEED(SEED), .CNT_W(16)) dut4 (
        .clk(clk), .rst(rst), .in_valid(v4), .in_data(d4), .in_k(k4), .in_ts(ts4),
        .scram_en(se4), .out_valid(ov4), .out_data(od4), .out_k(ok4),
        .out_locked(olk4), .com_cnt(cc4), .skp_cnt(sc4));

    int errors = 0;
    int checks = 0;

    // Model state, index 0 = NSYM=1 instance, 1 = NSYM=4 instance.
    logic [15:0] m_lfsr [2];
    logic [31:0] m_od   [2];
    logic [3:0]  m_ok   [2];
    logic        m_ov   [2];
    logic        m_lock [2];
    int          m_cc   [2];
    int          m_sc   [2];

    // Multiply by x^8 modulo x^16+x^5+x^4+x^3+1.
    function automatic logic [15:0] m_adv(input logic [15:0] l);
        logic [15:0] s;
        s = l;
        repeat (8) s = {s[14:0], 1'b0} ^ (s[15] ? 16'h0039 : 16'h0000);
        return s;
    endfunction

    function automatic logic [7:0] m_mask(input logic [15:0] l);
        logic [7:0] m;
        for (int i = 0; i < 8; i++) m[i] = l[15-i];
        return m;
    endfunction

    task automatic model(input int u, input int n, input int cmax, input logic v,
                         input logic [31:0] d, input logic [3:0] k, input logic [3:0] ts,
                         input logic se);
        logic [15:0] l;
        logic [7:0]  sym;
        logic [31:0] o;
        int ncom, nskp;
        if (!rst) begin
            m_lfsr[u] = SEED; m_od[u] = 0; m_ok[u] = 0; m_ov[u] = 0;
            m_lock[u] = 0; m_cc[u] = 0; m_sc[u] = 0;
        end else if (!v) begin
            m_ov[u] = 0;
        end else begin
            l = m_lfsr[u]; o = 0; ncom = 0; nskp = 0;
            for (int j = 0; j < n; j++) begin
                sym = d[8*j +: 8];
                if (k[j] && sym == 8'hBC) begin
                    o[8*j +: 8] = sym; l = SEED; ncom++;
                end else if (k[j] && sym == 8'h1C) begin
                    o[8*j +: 8] = sym; nskp++;
                end else if (!se) begin
                    o[8*j +: 8] = sym;
                end else if (k[j] || ts[j]) begin
                    o[8*j +: 8] = sym; l = m_adv(l);
                end else begin
                    o[8*j +: 8] = sym ^ m_mask(l); l = m_adv(l);
                end
            end
            m_lfsr[u] = l; m_od[u] = o; m_ok[u] = k & ((4'd1 << n) - 4'd1); m_ov[u] = 1;
            if (ncom > 0) m_lock[u] = 1;
`ifdef DESCRAM_STATS_EN
            m_cc[u] = (m_cc[u] + ncom > cmax) ? cmax : m_cc[u] + ncom;
            m_sc[u] = (m_sc[u] + nskp > cmax) ? cmax : m_sc[u] + nskp;
`endif
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set1(input logic v, input logic [7:0] d, input logic k, input logic ts, input logic se);
        v1 = v; d1 = d; k1 = k; ts1 = ts; se1 = se;
    endtask

    task automatic set4(input logic v, input logic [31:0] d, input logic [3:0] k,
                        input logic [3:0] ts, input logic se);
        v4 = v; d4 = d; k4 = k; ts4 = ts; se4 = se;
    endtask

    task automatic tick();
        @(posedge clk);
        model(0, 1, 15, v1, {24'h0, d1}, {3'b0, k1}, {3'b0, ts1}, se1);
        model(1, 4, 65535, v4, d4, k4, ts4, se4);
        #1;
        chk("ov1", ov1, m_ov[0]);
        chk("od1", od1, m_od[0]);
        chk("ok1", ok1, m_ok[0]);
        chk("lock1", olk1, m_lock[0]);
        chk("com1", cc1, m_cc[0]);
        chk("skp1", sc1, m_sc[0]);
        chk("ov4", ov4, m_ov[1]);
        chk("od4", od4, m_od[1]);
        chk("ok4", ok4, m_ok[1]);
        chk("lock4", olk4, m_lock[1]);
        chk("com4", cc4, m_cc[1]);
        chk("skp4", sc4, m_sc[1]);
        $display("t=%0t rst=%0b | n1 v=%0b d=%02h k=%0b se=%0b -> v=%0b d=%02h lk=%0b | n4 v=%0b d=%08h k=%04b ts=%04b se=%0b -> v=%0b d=%08h lk=%0b",
                 $time, rst, v1, d1, k1, se1, ov1, od1, olk1, v4, d4, k4, ts4, se4, ov4, od4, olk4);
    endtask

    function automatic logic [9:0] rand_slot();
        logic [9:0] r;
        case ($urandom_range(0, 9))
            0: r = {1'b1, 1'b0, 8'hBC};
            1: r = {1'b1, 1'b0, 8'h1C};
            2: r = {1'b1, 1'b0, 8'hF7};
            3: r = {1'b0, 1'b1, 8'($urandom)};
            default: r = {1'b0, 1'b0, 8'($urandom)};
        endcase
        return r;
    endfunction

    initial begin
        logic [9:0]  s;
        logic [31:0] rd;
        logic [3:0]  rk, rt;
        logic [7:0]  byte0;
        logic        rse1, rse4;

        rst = 1'b0;
        set1(0, 8'h00, 0, 0, 1);
        set4(0, 32'h0, 4'h0, 4'h0, 1);
        tick();
        chk("rst_od4", od4, 32'h0);
        chk("rst_lock1", olk1, 1'b0);
        tick();
        rst = 1'b1;

        // COM then zeros on both widths; the 4-wide COM sits in the last slot.
        set1(1, 8'hBC, 1, 0, 1); set4(1, 32'hBC000000, 4'b1000, 4'b0000, 1); tick();
        chk("tp_com1", od1, 8'hBC);
        chk("tp_lock_com", olk1, 1'b1);
        chk("tp_beat4a", od4, 32'hBCC017FF);
        set1(1, 8'h00, 0, 0, 1); set4(1, 32'h0, 4'h0, 4'h0, 1); tick();
        chk("tp_d1_ff", od1, 8'hFF);
        chk("tp_beat4b", od4, 32'h14C017FF);
        set4(0, 32'h0, 4'h0, 4'h0, 1);
        set1(1, 8'h00, 0, 0, 1); tick(); chk("tp_d1_17", od1, 8'h17);
        set1(1, 8'h00, 0, 0, 1); tick(); chk("tp_d1_c0", od1, 8'hC0);

        // SKP keeps the LFSR; TS body slots pass but still advance it.
        set1(1, 8'hBC, 1, 0, 1); set4(1, 32'h4A4A4ABC, 4'b0001, 4'b1110, 1); tick();
        chk("tp_ts_pass", od4, 32'h4A4A4ABC);
        set1(1, 8'h00, 0, 0, 1); set4(1, 32'h0, 4'h0, 4'h0, 1); tick();
        chk("tp_cs_ff", od1, 8'hFF);
        byte0 = od4[7:0];
        chk("tp_ts_adv", byte0, 8'h14);
        set4(0, 32'h0, 4'h0, 4'h0, 1);
        set1(1, 8'h1C, 1, 0, 1); tick(); chk("tp_skp", od1, 8'h1C);
        set1(1, 8'h00, 0, 0, 1); tick(); chk("tp_skp_hold", od1, 8'h17);

        // Bypass freezes the LFSR; re-enable picks up where it stopped.
        repeat (3) begin
            set1(1, 8'h55, 0, 0, 0); tick(); chk("byp_55", od1, 8'h55);
        end
        set1(1, 8'h00, 0, 0, 1); tick(); chk("byp_resume", od1, 8'hC0);
        set1(0, 8'hAA, 0, 0, 1); tick();
        chk("idle_hold", od1, 8'hC0);
        chk("idle_ov", ov1, 1'b0);

        repeat (20) begin
            set1(1, 8'h1C, 1, 0, 1); tick();
        end
`ifdef DESCRAM_STATS_EN
        chk("skp_sat", sc1, 4'd15);
`else
        chk("skp_tied", sc1, 4'd0);
`endif

        // Reset with a beat in flight.
        set1(1, 8'h33, 0, 0, 1); set4(1, 32'hBC1C00BC, 4'b1001, 4'b0000, 1);
        rst = 1'b0; tick();
        chk("mrst_od1", od1, 8'h0);
        chk("mrst_ov4", ov4, 1'b0);
        chk("mrst_lock4", olk4, 1'b0);
        rst = 1'b1;
        set1(1, 8'h00, 0, 0, 1); set4(0, 32'h0, 4'h0, 4'h0, 1); tick();
        chk("mrst_seed", od1, 8'hFF);

        rse1 = 1'b1; rse4 = 1'b1;
        for (int c = 0; c < 300; c++) begin
            if ($urandom_range(0, 19) == 0) rse1 = ~rse1;
            if ($urandom_range(0, 19) == 0) rse4 = ~rse4;
            s = rand_slot();
            set1($urandom_range(0, 4) != 0, s[7:0], s[9], s[8], rse1);
            for (int j = 0; j < 4; j++) begin
                s = rand_slot();
                rd[8*j +: 8] = s[7:0]; rk[j] = s[9]; rt[j] = s[8];
            end
            set4($urandom_range(0, 4) != 0, rd, rk, rt, rse4);
            rst = ($urandom_range(0, 49) != 0);
            tick();
        end
        rst = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lane_descrambler_nsym.md
# lane_descrambler_nsym

Parametrised per-lane receive descrambler for the PCIe 2.0 PHY Rx lane, sitting between the 8b/10b decoder and the ordered-set/deskew logic. It processes NSYM symbols per clock with a valid handshake and chains the LFSR across symbol slots within a cycle. It tracks COM-based LFSR lock and optionally counts COM/SKP symbols. K-codes, TS1/TS2 ordered-set bodies and bypass mode pass through unscrambled.

## Interface
Parameters:
- NSYM, 1, symbols per clock; legal values 1, 2, 4
- LFSR_SEED, 16'hFFFF, LFSR value loaded on reset and on COM
- CNT_W, 16, width of statistics counters

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-low reset
- in_valid  in  1  input symbols valid this cycle
- in_data  in  8*NSYM  symbols; slot j = in_data[8j+7:8j], slot 0 earliest on the wire
- in_k  in  NSYM  slot j is a K-code
- in_ts  in  NSYM  slot j is inside a TS1/TS2 body (never scrambled)
- scram_en  in  1  1 = descramble; 0 = bypass (loopback slave, end of configuration)
- out_valid  out  1  registered copy of in_valid
- out_data  out  8*NSYM  descrambled symbols
- out_k  out  NSYM  registered copy of in_k
- out_locked  out  1  at least one COM seen since reset
- com_cnt  out  CNT_W  COM symbols accepted (see Configuration)
- skp_cnt  out  CNT_W  SKP symbols accepted (see Configuration)

## Operation
- COM = K28.5 (8'hBC, in_k=1); SKP = K28.0 (8'h1C, in_k=1).
- Scrambler polynomial G(x)=x^16+x^5+x^4+x^3+1, Galois form; one "advance" = 8 serial bit-times. Mask for a symbol uses the LFSR value before that symbol's advance: out bit i = in bit i XOR lfsr[15-i].
- Per slot j, in order 0..NSYM-1, with L_j the LFSR entering slot j (L_0 = lfsr register):
  - COM: data passes; L_{j+1} = LFSR_SEED.
  - SKP: data passes; L_{j+1} = L_j (no advance).
  - other K-code, or in_ts[j]=1: data passes unmodified; L_{j+1} = advance(L_j).
  - otherwise: data XORed with mask of L_j; L_{j+1} = advance(L_j).
- lfsr register <= L_NSYM only when in_valid=1; holds otherwise.
- scram_en=0 with in_valid=1: all slots pass unmodified; LFSR frozen except that any COM still loads LFSR_SEED. Counters and lock still update.
- Lock FSM, two states: UNLOCKED (reset) -> LOCKED when an accepted cycle contains any COM; LOCKED held until reset. Data before lock is still processed with the reset seed; out_locked is informational.

## Timing
- Latency 1 clock: inputs sampled at edge n appear on out_* after edge n; no backpressure, one accepted beat per clock.
- in_valid=0: out_valid=0 next cycle; out_data/out_k hold previous values.
- Reset (rst=0 at an edge): lfsr=LFSR_SEED, out_valid=0, out_data=0, out_k=0, out_locked=0, com_cnt=0, skp_cnt=0. Reset mid-stream discards the in-flight beat; the first beat after release uses LFSR_SEED.
- out_locked rises on the same edge that registers the beat containing the first COM.
- Multiple COM/SKP in one beat: each applied in slot order; counters add the per-beat count.
- scram_en change takes effect on the beat sampled at the same edge.

## Configuration
- DESCRAM_STATS_EN defined: com_cnt/skp_cnt increment by number of COM/SKP slots in each accepted beat, saturating at 2^CNT_W-1 (no wrap).
- Not defined: counter logic absent; com_cnt and skp_cnt tied to 0.

## Test plan
- NSYM=1, scram_en=1: COM then data 0x00,0x00,0x00 -> out 0xBC,0xFF,0x17,0xC0; out_locked=1 from the COM beat.
- NSYM=1: COM, 0x00, SKP, 0x00 -> 0xBC, 0xFF, 0x1C, 0x17 (SKP does not advance).
- NSYM=4: beat {0x00,0x00,0x00,COM} then {0x00,0x00,...} -> second beat starts 0xFF,0x17,0xC0,0x14; COM reseeds mid-beat.
- NSYM=4: COM followed by in_ts=1 slots 0x4A -> pass as 0x4A; next non-TS data symbol uses LFSR advanced once per TS slot.
- scram_en=0, data 0x55 stream -> out 0x55 unchanged, LFSR frozen; re-enable resumes from frozen value.
- DESCRAM_STATS_EN, CNT_W=4: 20 SKP beats -> skp_cnt saturates at 15; rst low mid-stream -> all outputs 0 next cycle.
